regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter NREGS, default 32: register count, power of two, >= 8; ADDR_W = clog2(NREGS).
REQ-003 Parameter NRD, default 2: number of read ports, 1..4.
REQ-004 Parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding; 0 = none.
REQ-005 Parameter V0_IDX, default 2; A0_IDX, default 4: syscall code and argument registers.
REQ-006 clk  in  1: the single clock; all state updates on its rising edge.
REQ-007 reset  in  1: synchronous, active-high reset.
REQ-008 rd_addr  in  NRD*ADDR_W: packed read addresses; port i uses slice i.
REQ-009 rd_data  out  NRD*DATA_W: packed combinational read data; port i uses slice i.
REQ-010 wr0_en, wr1_en  in  1 each: write enables.
REQ-011 wr0_addr, wr1_addr  in  ADDR_W each: write addresses.
REQ-012 wr0_data, wr1_data  in  DATA_W each: write data.
REQ-013 ready  out  1: high when init is complete and writes are accepted.
REQ-014 syscall  in  1: syscall request level; its rising edge triggers a capture.
REQ-015 sys_valid  out  1: captured syscall pending.
REQ-016 sys_code, sys_arg  out  DATA_W each: captured V0 and A0 values.
REQ-017 sys_ready  in  1: consumer accepts the pending syscall.
REQ-018 sys_overrun  out  1: one-cycle pulse when a syscall edge is dropped.

Function
REQ-019 The controller SHALL have two states, INIT and RUN.
- reset forces INIT with clear counter = 0.
- INIT clears register[counter] each cycle, then increments the counter.
- After the cycle that clears register NREGS-1, the state becomes RUN.
- INIT therefore lasts exactly NREGS cycles after reset deasserts.
REQ-020 ready SHALL be 0 in INIT and 1 in RUN.
REQ-021 In INIT, wr0/wr1 and syscall edges SHALL be ignored and all rd_data slices SHALL read 0.
REQ-022 In RUN, an enabled write SHALL update register[addr] at the clock edge.
REQ-023 Writes to address 0 SHALL be discarded; reads of address 0 SHALL return 0 regardless of bypass.
REQ-024 When wr0 and wr1 are both enabled to the same address, wr1 SHALL win; different addresses SHALL both commit.
REQ-025 With BYPASS=1 in RUN, a read address equal to an enabled nonzero write address in the same cycle SHALL return that write data combinationally, with wr1 taking priority over wr0.
- Otherwise the read returns the stored value.
REQ-026 With BYPASS=0, reads SHALL return only stored values; a write is visible from the next cycle.
REQ-027 The syscall edge detector SHALL register syscall; an edge is syscall=1 with the previous sample 0. The previous sample resets to 0.
REQ-028 On an edge in RUN with sys_valid=0, or with sys_valid=1 and sys_ready=1 in the same cycle:
- capture stored (pre-write, non-bypassed) V0 into sys_code and A0 into sys_arg;
- sys_valid = 1 from the next cycle.
REQ-029 sys_valid SHALL hold, with sys_code and sys_arg stable, until a cycle with sys_ready=1. It then clears unless REQ-028 recaptures in that cycle.
REQ-030 An edge arriving while sys_valid=1 and sys_ready=0 SHALL be dropped; sys_overrun SHALL pulse high for the next cycle.
REQ-031 sys_ready while sys_valid=0 SHALL have no effect.

Reset
REQ-032 reset SHALL be sampled only at the clk rising edge and takes priority over all writes and captures.
REQ-033 Reset values: ready=0, sys_valid=0, sys_code=0, sys_arg=0, sys_overrun=0, state INIT.
REQ-034 reset asserted mid-INIT or mid-RUN SHALL restart INIT from counter 0.
- Pending syscalls are discarded.
- Registers are zeroed again over the next NREGS cycles.

Verification
REQ-035 Reset for 1 cycle, then poll -> ready rises after exactly 32 cycles (defaults); all 32 registers read 0; writes issued during INIT are lost.
REQ-036 In RUN, wr0 r5=0x1111 and wr1 r5=0x2222 in the same cycle, with rd port0 reading r5 -> same cycle 0x2222 (BYPASS=1); next cycle 0x2222. Repeat with BYPASS=0 -> same cycle 0, next cycle 0x2222.
REQ-037 Write r0=0xFFFF with rd_addr=0 -> rd_data 0 in the same cycle and afterwards.
REQ-038 r2=1, r4=0x2A, syscall 0->1, sys_ready=0 -> sys_valid=1, sys_code=1, sys_arg=0x2A held; a second edge -> sys_overrun pulses 1 cycle and data is unchanged; sys_ready=1 -> sys_valid=0 next cycle.
REQ-039 Edge in the same cycle as a write r4=7 (old value 3) -> sys_arg=3; edge coincident with sys_ready on a pending syscall -> sys_valid stays 1 with the new values.
REQ-040 NREGS=16, NRD=4: reset in RUN with sys_valid=1 -> sys_valid=0, ready=0 for 16 cycles, then all 4 ports read 0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with power-on clear sequencer and a syscall
// capture port that snapshots the V0/A0 registers on a rising syscall edge.
module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 32,
   parameter int NRD    = 2,
   parameter int BYPASS = 1,
   parameter int V0_IDX = 2,
   parameter int A0_IDX = 4,
   localparam int ADDR_W = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NRD*ADDR_W-1:0] rd_addr,
   output logic [NRD*DATA_W-1:0] rd_data,
   input  logic                  wr0_en,
   input  logic [ADDR_W-1:0]     wr0_addr,
   input  logic [DATA_W-1:0]     wr0_data,
   input  logic                  wr1_en,
   input  logic [ADDR_W-1:0]     wr1_addr,
   input  logic [DATA_W-1:0]     wr1_data,
   output logic                  ready,
   input  logic                  syscall,
   output logic                  sys_valid,
   output logic [DATA_W-1:0]     sys_code,
   output logic [DATA_W-1:0]     sys_arg,
   input  logic                  sys_ready,
   output logic                  sys_overrun
);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]   regs_q [NREGS];
   logic [DATA_W-1:0]   regs_d [NREGS];
   logic                sys_prev_q;
   logic                sys_valid_q, sys_valid_d;
   logic [DATA_W-1:0]   sys_code_q, sys_code_d;
   logic [DATA_W-1:0]   sys_arg_q, sys_arg_d;
   logic                sys_overrun_q, sys_overrun_d;
   logic                sys_edge;

   assign sys_edge = syscall & ~sys_prev_q;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      regs_d        = regs_q;
      sys_valid_d   = sys_valid_q;
      sys_code_d    = sys_code_q;
      sys_arg_d     = sys_arg_q;
      sys_overrun_d = 1'b0;
      case (state_q)
         S_INIT: begin
            regs_d[cnt_q] = '0;
            cnt_d         = cnt_q + 1'b1;
            if (cnt_q == ADDR_W'(NREGS - 1)) state_d = S_RUN;
         end
         default: begin
            // wr1 is applied last so it wins a same-address collision
            if (wr0_en && wr0_addr != '0) regs_d[wr0_addr] = wr0_data;
            if (wr1_en && wr1_addr != '0) regs_d[wr1_addr] = wr1_data;
            // capture uses stored (pre-write) values, never the bypass path
            if (sys_edge && (!sys_valid_q || sys_ready)) begin
               sys_valid_d = 1'b1;
               sys_code_d  = regs_q[V0_IDX];
               sys_arg_d   = regs_q[A0_IDX];
            end else begin
               if (sys_edge) sys_overrun_d = 1'b1;
               if (sys_valid_q && sys_ready) sys_valid_d = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_INIT;
         cnt_q         <= '0;
         sys_prev_q    <= 1'b0;
         sys_valid_q   <= 1'b0;
         sys_code_q    <= '0;
         sys_arg_q     <= '0;
         sys_overrun_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         regs_q        <= regs_d;
         sys_prev_q    <= syscall;
         sys_valid_q   <= sys_valid_d;
         sys_code_q    <= sys_code_d;
         sys_arg_q     <= sys_arg_d;
         sys_overrun_q <= sys_overrun_d;
      end
   end

   always_comb begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] v;
      rd_data = '0;
      a       = '0;
      v       = '0;
      for (int unsigned i = 0; i < NRD; i++) begin
         a = rd_addr[i*ADDR_W +: ADDR_W];
         v = regs_q[a];
         if (BYPASS != 0) begin
            if (wr0_en && wr0_addr == a) v = wr0_data;
            if (wr1_en && wr1_addr == a) v = wr1_data;
         end
         if (state_q != S_RUN || a == '0) v = '0;
         rd_data[i*DATA_W +: DATA_W] = v;
      end
   end

   assign ready       = (state_q == S_RUN);
   assign sys_valid   = sys_valid_q;
   assign sys_code    = sys_code_q;
   assign sys_arg     = sys_arg_q;
   assign sys_overrun = sys_overrun_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default config with bypass, a no-bypass
// twin sharing its inputs, and a 16-register / 4-read-port instance.
module tb_regfile_mp;

   logic        clk;
   logic        reset;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data_b, rd_data_n;
   logic        wr0_en, wr1_en;
   logic [4:0]  wr0_addr, wr1_addr;
   logic [31:0] wr0_data, wr1_data;
   logic        ready_b, ready_n;
   logic        syscall, sys_ready;
   logic        sys_valid_b, sys_valid_n;
   logic [31:0] sys_code_b, sys_code_n, sys_arg_b, sys_arg_n;
   logic        sys_overrun_b, sys_overrun_n;

   logic         reset2;
   logic [15:0]  rd_addr2;
   logic [127:0] rd_data2;
   logic         wr0_en2, wr1_en2;
   logic [3:0]   wr0_addr2, wr1_addr2;
   logic [31:0]  wr0_data2, wr1_data2;
   logic         ready2, syscall2, sys_ready2, sys_valid2, sys_overrun2;
   logic [31:0]  sys_code2, sys_arg2;

   int checks = 0;
   int failures = 0;
   int n;

   regfile_mp #(.BYPASS(1)) dut_b (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
      .ready(ready_b), .syscall(syscall), .sys_valid(sys_valid_b),
      .sys_code(sys_code_b), .sys_arg(sys_arg_b), .sys_ready(sys_ready),
      .sys_overrun(sys_overrun_b));

   regfile_mp #(.BYPASS(0)) dut_n (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
      .ready(ready_n), .syscall(syscall), .sys_valid(sys_valid_n),
      .sys_code(sys_code_n), .sys_arg(sys_arg_n), .sys_ready(sys_ready),
      .sys_overrun(sys_overrun_n));

   regfile_mp #(.NREGS(16), .NRD(4)) dut_s (
      .clk(clk), .reset(reset2), .rd_addr(rd_addr2), .rd_data(rd_data2),
      .wr0_en(wr0_en2), .wr0_addr(wr0_addr2), .wr0_data(wr0_data2),
      .wr1_en(wr1_en2), .wr1_addr(wr1_addr2), .wr1_data(wr1_data2),
      .ready(ready2), .syscall(syscall2), .sys_valid(sys_valid2),
      .sys_code(sys_code2), .sys_arg(sys_arg2), .sys_ready(sys_ready2),
      .sys_overrun(sys_overrun2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      reset = 1'b1; rd_addr = '0; syscall = 1'b0; sys_ready = 1'b0;
      wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
      wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
      reset2 = 1'b1; rd_addr2 = '0; syscall2 = 1'b0; sys_ready2 = 1'b0;
      wr0_en2 = 1'b0; wr0_addr2 = '0; wr0_data2 = '0;
      wr1_en2 = 1'b0; wr1_addr2 = '0; wr1_data2 = '0;
      tick();
      check("rst_ready", 64'(ready_b), 64'd0);
      check("rst_valid", 64'(sys_valid_b), 64'd0);
      check("rst_code", 64'(sys_code_b), 64'd0);
      check("rst_arg", 64'(sys_arg_b), 64'd0);
      check("rst_overrun", 64'(sys_overrun_b), 64'd0);
      check("rst_ready2", 64'(ready2), 64'd0);

      // writes held active through all of INIT must be lost
      reset = 1'b0; reset2 = 1'b0;
      wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'hDEAD;
      wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'hBEEF;
      syscall = 1'b1;
      rd_addr = {5'd9, 5'd7};
      settle();
      check("init_rd_bypass", rd_data_b, 64'd0);
      n = 0;
      while (!ready_b && n < 100) begin
         tick();
         n++;
      end
      wr0_en = 1'b0; wr1_en = 1'b0; syscall = 1'b0;
      check("init_cycles", 64'(n), 64'd32);
      check("init_no_syscall", 64'(sys_valid_b), 64'd0);
      for (int i = 0; i < 32; i++) begin
         rd_addr = {5'(31 - i), 5'(i)};
         settle();
         check($sformatf("clr_b_r%0d", i), 64'(rd_data_b[31:0]), 64'd0);
         check($sformatf("clr_n_r%0d", 31 - i), 64'(rd_data_n[63:32]), 64'd0);
      end

      // same-address double write: wr1 wins
      wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'h1111;
      wr1_en = 1'b1; wr1_addr = 5'd5; wr1_data = 32'h2222;
      rd_addr = {5'd0, 5'd5};
      settle();
      check("byp_same_cyc", 64'(rd_data_b[31:0]), 64'h2222);
      check("nobyp_same_cyc", 64'(rd_data_n[31:0]), 64'h0);
      tick();
      wr0_en = 1'b0; wr1_en = 1'b0;
      settle();
      check("byp_next_cyc", 64'(rd_data_b[31:0]), 64'h2222);
      check("nobyp_next_cyc", 64'(rd_data_n[31:0]), 64'h2222);

      // writes to r0 never land, even through bypass
      wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFF;
      rd_addr = {5'd0, 5'd0};
      settle();
      check("r0_same_cyc", 64'(rd_data_b[31:0]), 64'h0);
      tick();
      wr0_en = 1'b0;
      settle();
      check("r0_after", rd_data_b, 64'h0);

      // distinct addresses both commit; wr0-only bypass
      wr0_en = 1'b1; wr0_addr = 5'd6; wr0_data = 32'h66;
      wr1_en = 1'b1; wr1_addr = 5'd8; wr1_data = 32'h88;
      tick();
      wr1_en = 1'b0;
      wr0_addr = 5'd10; wr0_data = 32'hAA;
      rd_addr = {5'd6, 5'd10};
      settle();
      check("byp_wr0_only", 64'(rd_data_b[31:0]), 64'hAA);
      check("nobyp_wr0_only", 64'(rd_data_n[31:0]), 64'h0);
      check("dual_commit_r6", 64'(rd_data_b[63:32]), 64'h66);
      tick();
      wr0_en = 1'b0;
      rd_addr = {5'd8, 5'd10};
      settle();
      check("dual_commit_r8", 64'(rd_data_n[63:32]), 64'h88);
      check("r10_stored", 64'(rd_data_n[31:0]), 64'hAA);

      // syscall capture, hold, overrun and release
      wr0_en = 1'b1; wr0_addr = 5'd2; wr0_data = 32'h1;
      wr1_en = 1'b1; wr1_addr = 5'd4; wr1_data = 32'h2A;
      tick();
      wr0_en = 1'b0; wr1_en = 1'b0;
      syscall = 1'b1;
      tick();
      check("sc_valid", 64'(sys_valid_b), 64'd1);
      check("sc_code", 64'(sys_code_b), 64'h1);
      check("sc_arg", 64'(sys_arg_b), 64'h2A);
      check("sc_no_overrun", 64'(sys_overrun_b), 64'd0);
      tick();
      check("sc_hold_valid", 64'(sys_valid_b), 64'd1);
      syscall = 1'b0;
      tick();
      syscall = 1'b1;
      tick();
      check("ovr_pulse", 64'(sys_overrun_b), 64'd1);
      check("ovr_valid", 64'(sys_valid_b), 64'd1);
      check("ovr_code", 64'(sys_code_b), 64'h1);
      check("ovr_arg", 64'(sys_arg_b), 64'h2A);
      tick();
      check("ovr_one_cycle", 64'(sys_overrun_b), 64'd0);
      sys_ready = 1'b1;
      tick();
      check("sc_release", 64'(sys_valid_b), 64'd0);
      sys_ready = 1'b0; syscall = 1'b0;
      tick();
      check("sc_ready_idle", 64'(sys_valid_b), 64'd0);

      // capture sees pre-write A0; recapture on a consumed slot
      wr0_en = 1'b1; wr0_addr = 5'd4; wr0_data = 32'h3;
      tick();
      wr0_data = 32'h7;
      syscall = 1'b1;
      tick();
      wr0_en = 1'b0;
      check("prewrite_arg", 64'(sys_arg_b), 64'h3);
      check("prewrite_code", 64'(sys_code_b), 64'h1);
      rd_addr = {5'd0, 5'd4};
      settle();
      check("r4_after_write", 64'(rd_data_b[31:0]), 64'h7);
      syscall = 1'b0;
      wr0_en = 1'b1; wr0_addr = 5'd2; wr0_data = 32'h5;
      tick();
      wr0_en = 1'b0;
      syscall = 1'b1; sys_ready = 1'b1;
      tick();
      check("recap_valid", 64'(sys_valid_b), 64'd1);
      check("recap_code", 64'(sys_code_b), 64'h5);
      check("recap_arg", 64'(sys_arg_b), 64'h7);
      check("recap_no_overrun", 64'(sys_overrun_b), 64'd0);
      tick();
      check("recap_release", 64'(sys_valid_b), 64'd0);
      sys_ready = 1'b0; syscall = 1'b0;

      // small instance: reset from RUN with a pending syscall
      check("s_ready_run", 64'(ready2), 64'd1);
      wr0_en2 = 1'b1; wr0_addr2 = 4'd2; wr0_data2 = 32'h9;
      wr1_en2 = 1'b1; wr1_addr2 = 4'd3; wr1_data2 = 32'h3;
      tick();
      wr0_addr2 = 4'd5; wr0_data2 = 32'h5;
      wr1_addr2 = 4'd15; wr1_data2 = 32'hF;
      tick();
      wr0_en2 = 1'b0; wr1_en2 = 1'b0;
      rd_addr2 = {4'd15, 4'd5, 4'd3, 4'd2};
      syscall2 = 1'b1;
      settle();
      check("s_rd_pre", rd_data2[127:64], {32'hF, 32'h5});
      check("s_rd_pre_lo", rd_data2[63:0], {32'h3, 32'h9});
      tick();
      check("s_sc_valid", 64'(sys_valid2), 64'd1);
      check("s_sc_code", 64'(sys_code2), 64'h9);
      reset2 = 1'b1;
      tick();
      reset2 = 1'b0;
      check("s_rst_valid", 64'(sys_valid2), 64'd0);
      check("s_rst_ready", 64'(ready2), 64'd0);
      check("s_rst_code", 64'(sys_code2), 64'd0);
      check("s_init_rd_hi", rd_data2[127:64], 64'd0);
      n = 0;
      while (!ready2 && n < 100) begin
         tick();
         n++;
      end
      check("s_init_cycles", 64'(n), 64'd16);
      settle();
      for (int p = 0; p < 4; p++)
         check($sformatf("s_clr_port%0d", p), 64'(rd_data2[p*32 +: 32]), 64'd0);
      check("s_no_stale_sc", 64'(sys_valid2), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
